// File: rtl/capture_ring_sink.sv
// Circular capture buffer: fills from an AXI-stream slave, then replays the held samples
// oldest-first on an AXI-stream master through a registered read and an output register.
module capture_ring_sink #(
  parameter int size    = 32,
  parameter int saddr_w = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic               capture_done,
  input  logic [saddr_w:0]   buf_len,
  input  logic [size-1:0]    s_tdata,
  input  logic               s_tvalid,
  output logic               s_tready,
  output logic [size-1:0]    m_tdata,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic               m_tlast,
  output logic               busy,
  output logic               wrapped,
  output logic [saddr_w:0]   sample_count,
  output logic               drained
);

  localparam int DEPTH = 2 ** saddr_w;
  localparam logic [saddr_w:0]   DEPTH_C = (saddr_w + 1)'(DEPTH);
  localparam logic [saddr_w:0]   ONE_C   = (saddr_w + 1)'(1);
  localparam logic [saddr_w-1:0] PTR_ONE = saddr_w'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [saddr_w:0]   len_q, len_d;
  logic [saddr_w:0]   count_q, count_d;
  logic [saddr_w:0]   rem_q, rem_d;
  logic [saddr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [saddr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic               wrapped_q, wrapped_d;
  logic               rd_valid_q, rd_valid_d;
  logic               rd_last_q, rd_last_d;
  logic [size-1:0]    rd_data_q;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [size-1:0]    out_data_q, out_data_d;
  logic               drained_q, drained_d;

  logic [size-1:0]    mem [DEPTH];

  logic [saddr_w:0]   len_clamped;
  logic [saddr_w:0]   len_m1;
  logic               wr_en, wr_wrap, rd_wrap;
  logic               out_ready, s1_move, s1_ready, rd_issue;

  assign len_clamped = (buf_len == '0 || buf_len > DEPTH_C) ? DEPTH_C : buf_len;
  assign len_m1      = len_q - ONE_C;
  assign wr_en       = (state_q == ST_FILL) && s_tvalid;
  assign wr_wrap     = ({1'b0, wr_ptr_q} == len_m1);
  assign rd_wrap     = ({1'b0, rd_ptr_q} == len_m1);

  // Two-stage read pipeline: stage 1 is the memory read register, stage 2 the output register.
  assign out_ready = !out_valid_q || m_tready;
  assign s1_move   = rd_valid_q && out_ready;
  assign s1_ready  = !rd_valid_q || out_ready;
  assign rd_issue  = (state_q == ST_DRAIN) && !abort && (rem_q != '0) && s1_ready;

  // NOTE: every variable gets a default at the top so no path through the block infers a latch.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    count_d     = count_q;
    rem_d       = rem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    wrapped_d   = wrapped_q;
    rd_valid_d  = rd_valid_q;
    rd_last_d   = rd_last_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    drained_d   = 1'b0;

    if (abort) begin
      state_d     = ST_IDLE;
      rd_valid_d  = 1'b0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d   = ST_FILL;
            len_d     = len_clamped;
            wr_ptr_d  = '0;
            count_d   = '0;
            wrapped_d = 1'b0;
          end
        end
        ST_FILL: begin
          if (wr_en) begin
            wr_ptr_d = wr_wrap ? '0 : wr_ptr_q + PTR_ONE;
            if (count_q == len_q) wrapped_d = 1'b1;
            else                  count_d   = count_q + ONE_C;
          end
          // Use the post-write pointer so a beat coinciding with capture_done is replayed.
          if (capture_done) begin
            state_d    = ST_DRAIN;
            rd_ptr_d   = wrapped_d ? wr_ptr_d : '0;
            rem_d      = count_d;
            rd_valid_d = 1'b0;
          end
        end
        ST_DRAIN: begin
          if (count_q == '0) begin
            state_d   = ST_IDLE;
            drained_d = 1'b1;
          end else begin
            if (out_ready) begin
              out_valid_d = rd_valid_q;
              out_last_d  = rd_valid_q && rd_last_q;
              if (rd_valid_q) out_data_d = rd_data_q;
            end
            if (rd_issue) begin
              rd_valid_d = 1'b1;
              rd_last_d  = (rem_q == ONE_C);
              rd_ptr_d   = rd_wrap ? '0 : rd_ptr_q + PTR_ONE;
              rem_d      = rem_q - ONE_C;
            end else if (s1_move) begin
              rd_valid_d = 1'b0;
            end
            if (out_valid_q && m_tready && out_last_q) begin
              state_d     = ST_IDLE;
              drained_d   = 1'b1;
              out_valid_d = 1'b0;
              out_last_d  = 1'b0;
              rd_valid_d  = 1'b0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      len_q       <= DEPTH_C;
      count_q     <= '0;
      rem_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      wrapped_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      drained_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      wrapped_q   <= wrapped_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      drained_q   <= drained_d;
    end
  end

  // NOTE: the sample store and its read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= s_tdata;
    if (rd_issue) rd_data_q <= mem[rd_ptr_q];
  end

  assign s_tready     = (state_q == ST_FILL);
  assign busy         = (state_q != ST_IDLE);
  assign m_tdata      = out_data_q;
  assign m_tvalid     = out_valid_q;
  assign m_tlast      = out_last_q;
  assign wrapped      = wrapped_q;
  assign sample_count = count_q;
  assign drained      = drained_q;

endmodule

// File: tb/tb_capture_ring_sink.sv
// Randomized bench for capture_ring_sink against a queue model that keeps the newest
// min(n, len) samples of each fill and expects them back oldest-first.
module tb_capture_ring_sink;

  localparam int SIZE    = 32;
  localparam int SADDR_W = 10;
  localparam int DEPTH   = 1 << SADDR_W;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               start, abort, capture_done;
  logic [SADDR_W:0]   buf_len;
  logic [SIZE-1:0]    s_tdata;
  logic               s_tvalid, s_tready;
  logic [SIZE-1:0]    m_tdata;
  logic               m_tvalid, m_tready, m_tlast;
  logic               busy, wrapped, drained;
  logic [SADDR_W:0]   sample_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [SIZE-1:0] pushed_q[$];
  logic [SIZE-1:0] exp_q[$];

  capture_ring_sink #(.size(SIZE), .saddr_w(SADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .capture_done(capture_done), .buf_len(buf_len),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .busy(busy), .wrapped(wrapped), .sample_count(sample_count), .drained(drained)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic int eff_len(input int cfg);
    return (cfg == 0 || cfg > DEPTH) ? DEPTH : cfg;
  endfunction

  // Streams n samples into a fresh fill; base >= 0 gives base+i data, otherwise random.
  task automatic fill(input int cfg, input int n, input int base, input bit gaps,
                      input bit done_with_last, input bit do_done);
    int sent = 0;
    int leff = eff_len(cfg);
    int keep;
    pushed_q.delete();
    exp_q.delete();
    start   = 1'b1;
    buf_len = (SADDR_W + 1)'(cfg);
    cycle();
    start   = 1'b0;
    buf_len = (SADDR_W + 1)'($urandom);
    check("fill_s_tready", s_tready, 1'b1);
    check("fill_busy", busy, 1'b1);
    while (sent < n) begin
      s_tvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      start    = gaps ? ($urandom_range(0, 7) == 0) : 1'b0;
      if (s_tvalid) begin
        s_tdata = (base >= 0) ? SIZE'(base + sent) : SIZE'($urandom);
        pushed_q.push_back(s_tdata);
        sent++;
        if (sent == n && done_with_last && do_done) capture_done = 1'b1;
      end
      cycle();
    end
    s_tvalid = 1'b0;
    start    = 1'b0;
    if (do_done && !(done_with_last && n > 0)) begin
      capture_done = 1'b1;
      cycle();
    end
    capture_done = 1'b0;
    keep = (n < leff) ? n : leff;
    for (int i = n - keep; i < n; i++) exp_q.push_back(pushed_q[i]);
    check("fill_wrapped", wrapped, (n > leff));
    check("fill_sample_count", sample_count, keep);
  endtask

  // Called in the first DRAIN cycle; consumes exp_q and checks the replay stream.
  task automatic drain(input int mode);
    int idx = 0;
    int k = 0;
    int first = -1;
    int n = exp_q.size();
    int budget = 4 * n + 40;
    bit done = (n == 0);
    bit prev_stall = 1'b0;
    logic [SIZE-1:0] prev_d = '0;
    logic prev_l = 1'b0;
    check("drain_entry_busy", busy, 1'b1);
    check("drain_entry_s_tready", s_tready, 1'b0);
    if (n == 0) begin
      check("empty_no_valid", m_tvalid, 1'b0);
      check("empty_drained_early", drained, 1'b0);
      cycle();
    end
    while (!done && k < budget) begin
      unique case (mode)
        0:       m_tready = 1'b1;
        1:       m_tready = (k % 2 == 0);
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
      if (mode == 2) begin
        capture_done = 1'($urandom_range(0, 1));
        start        = ($urandom_range(0, 5) == 0);
      end
      if (prev_stall) begin
        check("stall_valid", m_tvalid, 1'b1);
        check("stall_data", m_tdata, prev_d);
        check("stall_last", m_tlast, prev_l);
      end
      if (drained) check("drained_early", drained, 1'b0);
      if (m_tvalid && first < 0) first = k;
      if (m_tvalid && m_tready) begin
        check("beat_data", m_tdata, exp_q[idx]);
        check("beat_last", m_tlast, (idx == n - 1));
        if (idx == n - 1) done = 1'b1;
        idx++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_d     = m_tdata;
      prev_l     = m_tlast;
      cycle();
      k++;
    end
    start        = 1'b0;
    capture_done = 1'b0;
    m_tready     = 1'b0;
    if (!done) check("drain_timeout", 1'b0, 1'b1);
    if (n > 0) check("first_valid_latency", first, 2);
    check("beat_count", idx, n);
    check("drained_pulse", drained, 1'b1);
    check("drained_idle", busy, 1'b0);
    check("drained_no_valid", m_tvalid, 1'b0);
    cycle();
    check("drained_one_cycle", drained, 1'b0);
  endtask

  initial begin
    int hs;
    int k;
    reset_n      = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    capture_done = 1'b0;
    buf_len      = '0;
    s_tdata      = '0;
    s_tvalid     = 1'b0;
    m_tready     = 1'b0;
    #3;
    check("rst_busy", busy, 1'b0);
    check("rst_s_tready", s_tready, 1'b0);
    check("rst_m_tvalid", m_tvalid, 1'b0);
    check("rst_m_tlast", m_tlast, 1'b0);
    check("rst_m_tdata", m_tdata, '0);
    check("rst_sample_count", sample_count, '0);
    check("rst_wrapped", wrapped, 1'b0);
    check("rst_drained", drained, 1'b0);
    #9 reset_n = 1'b1;
    cycle();

    // Short fill without wrap, capture_done on the last beat.
    fill(8, 5, 'h10, 1'b0, 1'b1, 1'b1);
    drain(0);

    // Wrapped ring of length 8.
    fill(8, 11, 1, 1'b0, 1'b0, 1'b1);
    drain(0);

    // buf_len 0 clamps to full depth; replay with ready toggling every cycle.
    fill(0, 1030, -1, 1'b0, 1'b0, 1'b1);
    drain(1);

    // No samples at all.
    fill(8, 0, 0, 1'b0, 1'b0, 1'b1);
    drain(0);

    // Abort mid-replay after three beats, then a clean refill.
    fill(8, 6, 'h40, 1'b0, 1'b0, 1'b1);
    m_tready = 1'b1;
    hs = 0;
    k  = 0;
    while (hs < 3 && k < 50) begin
      if (m_tvalid && m_tready) begin
        check("abort_beat", m_tdata, exp_q[hs]);
        hs++;
      end
      cycle();
      k++;
    end
    check("abort_pre_beats", hs, 3);
    check("abort_pre_valid", m_tvalid, 1'b1);
    abort = 1'b1;
    cycle();
    abort    = 1'b0;
    m_tready = 1'b0;
    check("abort_m_tvalid", m_tvalid, 1'b0);
    check("abort_m_tlast", m_tlast, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_s_tready", s_tready, 1'b0);
    check("abort_drained", drained, 1'b0);
    cycle();
    check("abort_drained_late", drained, 1'b0);
    check("abort_valid_late", m_tvalid, 1'b0);
    fill(4, 4, 'h80, 1'b1, 1'b0, 1'b1);
    drain(2);

    // Asynchronous reset in the middle of a wrapped fill.
    fill(4, 6, 'h90, 1'b0, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_s_tready", s_tready, 1'b0);
    check("arst_wrapped", wrapped, 1'b0);
    check("arst_sample_count", sample_count, '0);
    check("arst_m_tvalid", m_tvalid, 1'b0);
    check("arst_m_tdata", m_tdata, '0);
    check("arst_drained", drained, 1'b0);
    #3 reset_n = 1'b1;
    cycle();
    fill(3, 5, -1, 1'b0, 1'b0, 1'b1);
    drain(0);

    // Randomized lengths, sample counts, gaps, ready and ignored control noise.
    for (int it = 0; it < 10; it++) begin
      int cfg;
      int leff;
      int n;
      cfg  = (it == 4) ? 2000 : $urandom_range(1, 16);
      leff = eff_len(cfg);
      n    = (leff > 40) ? $urandom_range(0, 50) : $urandom_range(0, 2 * leff + 3);
      fill(cfg, n, -1, 1'b1, 1'($urandom_range(0, 1)), 1'b1);
      drain(2);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
